// File: rtl/burst_tx_gen.sv
// Valid/ready burst source: emits start-triggered bursts of incrementing, constant,
// LFSR or walking-one data, flags the final beat with last, then idles for a fixed gap.
module burst_tx_gen #(
   parameter int                DATA_W    = 32,
   parameter int                LEN_W     = 8,
   parameter int                GAP_CYC   = 4,
   parameter logic [DATA_W-1:0] INC_STEP  = DATA_W'(1),
   parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h80200003)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [1:0]        mode_i,
   input  logic [LEN_W-1:0]  burst_len_i,
   input  logic [DATA_W-1:0] seed_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic              last_o,
   input  logic              ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [15:0]       burst_cnt_o,
   output logic [1:0]        state_o
);

   // Handshake: a beat moves on every rising edge where valid_o && ready_i; once
   // raised, valid_o and the beat payload hold until that handshake (or rst_i).

   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [GAP_W-1:0]  gap_q, gap_d;

   function automatic logic [DATA_W-1:0] next_data(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] d);
      case (m)
         2'd0:    next_data = d + INC_STEP;
         2'd1:    next_data = d;
         2'd2:    next_data = (d >> 1) ^ (d[0] ? LFSR_TAPS : '0);
         default: next_data = {d[DATA_W-2:0], d[DATA_W-1]};
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      len_d   = len_q;
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && (burst_len_i != '0)) begin
               mode_d  = mode_i;
               len_d   = burst_len_i;
               // A zero seed would lock the LFSR and walking-one patterns at zero.
               data_d  = (mode_i[1] && (seed_i == '0)) ? DATA_W'(1) : seed_i;
               idx_d   = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (valid_q && ready_i) begin
               if (idx_q == len_q - LEN_W'(1)) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  cnt_d   = cnt_q + 16'd1;
                  gap_d   = '0;
                  if (GAP_CYC == 0) begin
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end else begin
                     state_d = S_GAP;
                  end
               end else begin
                  data_d = next_data(mode_q, data_q);
                  idx_d  = idx_q + LEN_W'(1);
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_W'(GAP_CYC - 1)) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         mode_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign last_o      = valid_q && (idx_q == len_q - LEN_W'(1));
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign burst_cnt_o = cnt_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_burst_tx_gen.sv
// Bench for burst_tx_gen: directed bursts push hand-computed beats into a queue,
// a negedge monitor pops and compares every handshake.
module tb_burst_tx_gen;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [1:0]        mode = '0;
   logic [LEN_W-1:0]  burst_len = '0;
   logic [DATA_W-1:0] seed = '0;
   logic              ready = 1'b1;
   logic [DATA_W-1:0] data;
   logic              valid, last, busy, done;
   logic [15:0]       burst_cnt;
   logic [1:0]        state;

   logic [DATA_W:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int hs_cnt = 0;
   int done_cnt = 0;

   burst_tx_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_CYC(4)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
      .burst_len_i(burst_len), .seed_i(seed), .data_o(data), .valid_o(valid),
      .last_o(last), .ready_i(ready), .busy_o(busy), .done_o(done),
      .burst_cnt_o(burst_cnt), .state_o(state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst && done) done_cnt++;
      if (!rst && valid && ready) begin
         hs_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat actual=%0h last=%0b required=none", data, last);
         end else begin
            logic [DATA_W:0] e;
            e = exp_q.pop_front();
            if ({last, data} !== e) begin
               failures++;
               $display("FAIL beat actual=%0b/%0h required=%0b/%0h",
                        last, data, e[DATA_W], e[DATA_W-1:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic push(input logic [DATA_W-1:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   task automatic do_start(input logic [1:0] m, input logic [LEN_W-1:0] len,
                           input logic [DATA_W-1:0] s);
      @(posedge clk); #1;
      start = 1'b1; mode = m; burst_len = len; seed = s;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 300);
      check(name, {63'd0, busy}, 64'd0);
      check({name, "_queue"}, exp_q.size(), 0);
   endtask

   initial begin
      int hs0, dn0;
      logic [15:0] cnt0;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_data", data, 0);
      check("rst_valid", valid, 0);
      check("rst_last", last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cnt", burst_cnt, 0);

      // 1: incrementing burst with full throughput, done/busy timing
      push(5, 0); push(6, 0); push(7, 0); push(8, 1);
      do_start(2'd0, 8'd4, 32'd5);
      @(negedge clk);
      check("latency_valid", valid, 1);
      check("latency_data", data, 5);
      repeat (3) @(negedge clk);
      @(negedge clk);
      check("t1_done", done, 1);
      check("t1_valid_low", valid, 0);
      check("t1_cnt", burst_cnt, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t1_busy_gap", busy, 1);
         check("t1_done_one_cycle", done, 0);
      end
      @(negedge clk);
      check("t1_busy_low", busy, 0);

      // 2: back-pressure while data=6
      hs0 = hs_cnt; dn0 = done_cnt;
      push(5, 0); push(6, 0); push(7, 0); push(8, 1);
      do_start(2'd0, 8'd4, 32'd5);
      @(posedge clk); #1 ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_stall_valid", valid, 1);
         check("t2_stall_data", data, 6);
         check("t2_stall_last", last, 0);
         @(posedge clk); #1;
      end
      ready = 1'b1;
      wait_idle("t2_idle");
      check("t2_handshakes", hs_cnt - hs0, 4);
      check("t2_dones", done_cnt - dn0, 1);

      // 3: LFSR, including the zero-seed substitution
      push(32'h00000001, 0); push(32'h80200003, 0); push(32'hC0300002, 1);
      do_start(2'd2, 8'd3, 32'd1);
      wait_idle("t3_lfsr");
      push(32'h00000001, 1);
      do_start(2'd2, 8'd1, 32'd0);
      wait_idle("t3_lfsr_seed0");

      // 4: walking one wraps MSB to LSB; increment wraps at all-ones
      push(32'h80000000, 0); push(32'h00000001, 0); push(32'h00000002, 1);
      do_start(2'd3, 8'd3, 32'h80000000);
      wait_idle("t4_walk");
      push(32'hFFFFFFFF, 0); push(32'h00000000, 1);
      do_start(2'd0, 8'd2, 32'hFFFFFFFF);
      wait_idle("t4_wrap");

      // 5: zero length ignored; starts during SEND and GAP ignored; single beat
      cnt0 = burst_cnt; dn0 = done_cnt;
      do_start(2'd0, 8'd0, 32'd9);
      repeat (4) begin
         @(negedge clk);
         check("t5_len0_valid", valid, 0);
         check("t5_len0_busy", busy, 0);
      end
      check("t5_len0_cnt", burst_cnt, cnt0);
      check("t5_len0_done", done_cnt - dn0, 0);

      cnt0 = burst_cnt;
      push(32'hA5, 0); push(32'hA5, 0); push(32'hA5, 1);
      do_start(2'd1, 8'd3, 32'hA5);
      start = 1'b1; mode = 2'd0; burst_len = 8'd5; seed = 32'h77;
      @(posedge clk); #1 start = 1'b0;
      begin
         int n = 0;
         while (!done && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("t5_done_seen", done, 1);
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_idle("t5_ignore");
      repeat (6) begin
         @(negedge clk);
         check("t5_no_queued_start", valid, 0);
      end
      check("t5_cnt", burst_cnt - cnt0, 1);

      dn0 = done_cnt;
      push(32'h1234, 1);
      do_start(2'd0, 8'd1, 32'h1234);
      @(negedge clk);
      check("t5_len1_last", last, 1);
      wait_idle("t5_len1");
      check("t5_len1_done", done_cnt - dn0, 1);

      // 6: reset on the second beat abandons the burst
      dn0 = done_cnt;
      push(32'd100, 0);
      do_start(2'd0, 8'd8, 32'd100);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t6_valid", valid, 0);
      check("t6_busy", busy, 0);
      check("t6_cnt", burst_cnt, 0);
      check("t6_done", done_cnt - dn0, 0);
      check("t6_state", state, 0);
      push(32'd100, 0); push(32'd101, 1);
      do_start(2'd0, 8'd2, 32'd100);
      wait_idle("t6_fresh");
      check("t6_cnt_after", burst_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/burst_tx_gen.md
Name: burst_tx_gen

Overview:
Parametrised valid/ready burst source that emits programmable-length bursts of generated test data. It supports incrementing, constant, LFSR and walking-one patterns, marks the final beat of each burst with last, and inserts a fixed idle gap between bursts. It drives rx-side sinks and stress benches in the tx/rx test chain, and replaces the fixed 8-beat incrementing transmitter with a start-triggered, back-pressure-correct generator.

Parameters:
DATA_W, 32, width of data, seed and pattern arithmetic
LEN_W, 8, width of burst_len; maximum burst length is 2^LEN_W-1
GAP_CYC, 4, idle cycles after the final beat before a new start is accepted; 0 means no gap
INC_STEP, 1, increment added per beat in mode 0
LFSR_TAPS, 32'h80200003, Galois feedback mask for mode 2

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle burst request; sampled only in IDLE
mode  in  2  pattern: 0 incr, 1 const, 2 lfsr, 3 walking-one; latched at accepted start
burst_len  in  LEN_W  beats in burst; latched at accepted start
seed  in  DATA_W  first data word; latched at accepted start
data  out  DATA_W  beat payload
valid  out  1  beat valid
last  out  1  high with valid on final beat
ready  in  1  sink accepts beat when valid && ready
busy  out  1  high in SEND and GAP
done  out  1  one-cycle pulse after final handshake
burst_cnt  out  16  completed bursts, wraps mod 2^16

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; data=0, valid=0, last=0, busy=0, done=0, burst_cnt=0, beat index=0. Reset mid-burst abandons the burst with no done pulse; valid is low the cycle after.
- FSM states: IDLE, SEND, GAP.
- IDLE: start=1 and burst_len!=0 -> latch mode/len/seed; data<=seed (mode 2 or 3 with seed 0 loads 1); valid<=1; busy<=1; beat index<=0; go SEND. start with burst_len=0 is ignored (stays IDLE, no done, burst_cnt unchanged).
- Latency: start sampled at edge N -> valid=1 and data=seed visible after edge N (cycle N+1).
- SEND: a beat transfers on any edge where valid && ready.
  - Non-final beat: data<=next(data), index<=index+1, valid stays 1.
  - Final beat (index==len-1): valid<=0, last<=0, done<=1 for one cycle, burst_cnt<=burst_cnt+1; go GAP, or go IDLE with busy<=0 if GAP_CYC=0.
- valid && !ready: data, last and index hold exactly. valid never deasserts without a handshake, except on rst.
- last = valid && index==len-1. With len=1, last is high on the first beat.
- next(): mode 0 is d+INC_STEP mod 2^DATA_W (wraps all-ones to INC_STEP-1); mode 1 is d; mode 2 is (d>>1) ^ (d[0] ? LFSR_TAPS : 0); mode 3 rotates d left by 1.
- GAP: count GAP_CYC cycles with valid=0 and busy=1, then go IDLE with busy<=0.
- start in SEND or GAP is ignored, not queued. Mode, len and seed changes outside an accepted start have no effect.
- rst has priority over every other event in the same cycle.

Test Plan:
1. mode0, seed 5, len 4, ready=1 -> data 5,6,7,8 on consecutive valid cycles; last only on 8; done pulse the cycle after beat 8; burst_cnt=1; busy low 4 cycles after done (GAP_CYC=4).
2. Same burst, ready=0 for 3 cycles while data=6 -> valid stays 1, data holds 6, last=0; stream resumes 7,8; exactly 4 handshakes total.
3. mode2, seed 1, len 3 -> 0x00000001, 0x80200003, 0xC0300002 with last; mode2 seed 0 -> first beat 0x00000001.
4. mode3, seed 0x80000000, len 3 -> 0x80000000, 0x00000001, 0x00000002. mode0, seed 0xFFFFFFFF, len 2 -> 0xFFFFFFFF, 0x00000000.
5. start with len 0 -> no valid, no done, burst_cnt unchanged. start pulses during SEND and during GAP -> ignored; only one burst is produced. len 1 -> single beat with last=1 and done.
6. rst at the 2nd beat of an 8-beat burst -> valid=0, busy=0, burst_cnt=0 next cycle, no done; a following start produces a fresh burst from seed.
